pcie_switch_param: RTL and testbench

//  Parametrised N-channel PCIe-style switch core: N class input FIFOs, round-robin arbiter, destination demux and N output FIFOs.
//  - Class field of data_in picks the input FIFO; dest field picks the output FIFO.
//  - Arbiter stalls while any output FIFO is almost full; thresholds are programmed in INIT.
//  - Per-output pop counters are readable over a req/idx port. Successor of the fixed 4-channel switch.

---
 rtl/pcie_switch_param.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pcie_switch_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_switch_param.sv
// rtl/pcie_switch_param.sv - parametrised N-channel switch core with class/dest routing
// Purpose: NUM_CH class input FIFOs feed an arbiter. The arbiter is round-robin by
// default, or strict priority when the macro ARB_STRICT_PRIO_EN is defined. A granted
// word passes through one pipe register and is written to the output FIFO selected by
// its dest field. Per-output pop counters are readable through req/idx.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   init, umbral_L, umbral_H   INIT request, almost-empty / almost-full thresholds
//   push, data_in, in_full     input word (class field picks FIFO), per-input full
//   pop, data_out              per-output read strobe, registered read data
//   out_empty                  per-output empty
//   out_almost_full            per-output occupancy >= latched high threshold
//   out_almost_empty           per-output occupancy <= latched low threshold
//   req, idx                   pop-counter read request and index
//   data_count, valid_count    registered counter read result
//   state, idle                FSM state, IDLE indicator
module pcie_switch_param #(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 5,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int OCC_W      = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [OCC_W-1:0]         umbral_L,
    input  logic [OCC_W-1:0]         umbral_H,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        pop,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        out_empty,
    output logic [NUM_CH-1:0]        out_almost_full,
    output logic [NUM_CH-1:0]        out_almost_empty,
    output logic [NUM_CH-1:0]        in_full,
    input  logic                     req,
    input  logic [CH_W-1:0]          idx,
    output logic [CNT_W-1:0]         data_count,
    output logic                     valid_count,
    output logic [2:0]               state,
    output logic                     idle
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [OCC_W-1:0]     thr_l_q, thr_l_d, thr_h_q, thr_h_d;

    logic [DATA_W-1:0]    in_mem_q  [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0]    in_mem_d  [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     in_wp_q [NUM_CH], in_wp_d [NUM_CH];
    logic [PTR_W-1:0]     in_rp_q [NUM_CH], in_rp_d [NUM_CH];
    logic [OCC_W-1:0]     in_occ_q[NUM_CH], in_occ_d[NUM_CH];

    logic [DATA_W-1:0]    out_mem_q [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0]    out_mem_d [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     out_wp_q [NUM_CH], out_wp_d [NUM_CH];
    logic [PTR_W-1:0]     out_rp_q [NUM_CH], out_rp_d [NUM_CH];
    logic [OCC_W-1:0]     out_occ_q[NUM_CH], out_occ_d[NUM_CH];

    logic                 pipe_valid_q, pipe_valid_d;
    logic [DATA_W-1:0]    pipe_data_q, pipe_data_d;

    logic [DATA_W-1:0]    dout_q[NUM_CH], dout_d[NUM_CH];
    logic [CNT_W-1:0]     cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [CNT_W-1:0]     data_count_q, data_count_d;
    logic                 valid_count_q, valid_count_d;

`ifndef ARB_STRICT_PRIO_EN
    // Next input FIFO to be offered first; advanced past each grant.
    logic [CH_W-1:0]      rr_q, rr_d;
    logic [CH_W-1:0]      cand;
`endif

    logic [NUM_CH-1:0]    in_nempty, in_wr, in_rd, out_wr, out_pop;
    logic                 grant_valid, push_ok, push_err, flush;
    logic [CH_W-1:0]      grant_idx, push_cls, pipe_dest;

    assign push_cls  = data_in[DATA_W-1 -: CH_W];
    assign pipe_dest = pipe_data_q[DATA_W-CH_W-1 -: CH_W];
    assign push_ok   = (state_q != ST_RESET) && (state_q != ST_INIT);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flags
        assign in_nempty[g]        = (in_occ_q[g] != '0);
        assign in_full[g]          = (in_occ_q[g] == OCC_W'(FIFO_DEPTH));
        assign out_empty[g]        = (out_occ_q[g] == '0);
        assign out_almost_full[g]  = (out_occ_q[g] >= thr_h_q);
        assign out_almost_empty[g] = (out_occ_q[g] <= thr_l_q);
        assign data_out[g*DATA_W +: DATA_W] = dout_q[g];
        assign in_wr[g]   = push && push_ok && (push_cls == CH_W'(g)) && !in_full[g];
        assign in_rd[g]   = grant_valid && (grant_idx == CH_W'(g));
        assign out_wr[g]  = pipe_valid_q && (pipe_dest == CH_W'(g));
        assign out_pop[g] = pop[g] && !out_empty[g];
    end

    assign push_err    = push && push_ok && in_full[push_cls];
    assign data_count  = data_count_q;
    assign valid_count = valid_count_q;
    assign state       = state_q;
    assign idle        = (state_q == ST_IDLE);

    // Grant selection: descending scan so the highest-priority candidate is written last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifndef ARB_STRICT_PRIO_EN
        cand        = '0;
`endif
        if (state_q == ST_ACTIVE && !(|out_almost_full)) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
`ifdef ARB_STRICT_PRIO_EN
                if (in_nempty[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(k);
                end
`else
                cand = rr_q + CH_W'(k);
                if (in_nempty[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
`endif
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        thr_l_d       = thr_l_q;
        thr_h_d       = thr_h_q;
        in_mem_d      = in_mem_q;
        out_mem_d     = out_mem_q;
        in_wp_d       = in_wp_q;
        in_rp_d       = in_rp_q;
        in_occ_d      = in_occ_q;
        out_wp_d      = out_wp_q;
        out_rp_d      = out_rp_q;
        out_occ_d     = out_occ_q;
        dout_d        = dout_q;
        cnt_d         = cnt_q;
        flush         = 1'b0;
        pipe_valid_d  = grant_valid;
        pipe_data_d   = in_mem_q[grant_idx][in_rp_q[grant_idx]];
        valid_count_d = req;
        data_count_d  = req ? cnt_q[idx] : data_count_q;
`ifndef ARB_STRICT_PRIO_EN
        rr_d          = grant_valid ? grant_idx + CH_W'(1) : rr_q;
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            if (in_wr[i]) begin
                in_mem_d[i][in_wp_q[i]] = data_in;
                in_wp_d[i] = in_wp_q[i] + PTR_W'(1);
            end
            if (in_rd[i]) begin
                in_rp_d[i] = in_rp_q[i] + PTR_W'(1);
            end
            in_occ_d[i] = in_occ_q[i] + OCC_W'(in_wr[i]) - OCC_W'(in_rd[i]);

            if (out_pop[i]) begin
                dout_d[i]   = out_mem_q[i][out_rp_q[i]];
                out_rp_d[i] = out_rp_q[i] + PTR_W'(1);
                cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end
            if (out_wr[i]) begin
                out_mem_d[i][out_wp_q[i]] = pipe_data_q;
                out_wp_d[i] = out_wp_q[i] + PTR_W'(1);
            end
            out_occ_d[i] = out_occ_q[i] + OCC_W'(out_wr[i]) - OCC_W'(out_pop[i]);
        end

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                thr_l_d = umbral_L;
                // Clamping keeps one free slot so a stalled in-flight pipe word always lands.
                thr_h_d = (umbral_H > OCC_W'(FIFO_DEPTH - 1)) ? OCC_W'(FIFO_DEPTH - 1) : umbral_H;
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE, ST_ERROR: begin
                if (init) begin
                    state_d = ST_INIT;
                    flush   = (state_q == ST_ERROR);
                end else if (push_err) begin
                    state_d = ST_ERROR;
                end else if (state_q == ST_IDLE && (|in_nempty)) begin
                    state_d = ST_ACTIVE;
                end else if (state_q == ST_ACTIVE && !(|in_nempty) && !pipe_valid_q
                             && (&out_empty)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ERROR;
        endcase

        // Leaving ERROR through INIT discards queued words; counters and data_out survive.
        if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_wp_d[i]   = '0;
                in_rp_d[i]   = '0;
                in_occ_d[i]  = '0;
                out_wp_d[i]  = '0;
                out_rp_d[i]  = '0;
                out_occ_d[i] = '0;
            end
            pipe_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RESET;
            thr_l_q       <= OCC_W'(1);
            thr_h_q       <= OCC_W'(FIFO_DEPTH - 1);
            in_wp_q       <= '{default: '0};
            in_rp_q       <= '{default: '0};
            in_occ_q      <= '{default: '0};
            out_wp_q      <= '{default: '0};
            out_rp_q      <= '{default: '0};
            out_occ_q     <= '{default: '0};
            pipe_valid_q  <= 1'b0;
            pipe_data_q   <= '0;
            dout_q        <= '{default: '0};
            cnt_q         <= '{default: '0};
            data_count_q  <= '0;
            valid_count_q <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
            rr_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            thr_l_q       <= thr_l_d;
            thr_h_q       <= thr_h_d;
            in_wp_q       <= in_wp_d;
            in_rp_q       <= in_rp_d;
            in_occ_q      <= in_occ_d;
            out_wp_q      <= out_wp_d;
            out_rp_q      <= out_rp_d;
            out_occ_q     <= out_occ_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_data_q   <= pipe_data_d;
            dout_q        <= dout_d;
            cnt_q         <= cnt_d;
            data_count_q  <= data_count_d;
            valid_count_q <= valid_count_d;
`ifndef ARB_STRICT_PRIO_EN
            rr_q          <= rr_d;
`endif
        end
        // Storage contents are qualified by pointers/occupancy, so they need no reset.
        in_mem_q  <= in_mem_d;
        out_mem_q <= out_mem_d;
    end

endmodule

// File: tb/tb_pcie_switch_param.sv
// tb/tb_pcie_switch_param.sv - randomized self-checking bench for pcie_switch_param
module tb_pcie_switch_param;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 5;
    localparam int CH_W   = 2;
    localparam int OCC_W  = 4;

    logic                     clk = 1'b0;
    logic                     reset, init, push, req;
    logic [OCC_W-1:0]         umbral_L, umbral_H;
    logic [DATA_W-1:0]        data_in;
    logic [NUM_CH-1:0]        pop;
    logic [CH_W-1:0]          idx;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        out_empty, out_almost_full, out_almost_empty, in_full;
    logic [CNT_W-1:0]         data_count;
    logic                     valid_count, idle;
    logic [2:0]               state;

    pcie_switch_param #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_L(umbral_L), .umbral_H(umbral_H),
        .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
        .out_empty(out_empty), .out_almost_full(out_almost_full),
        .out_almost_empty(out_almost_empty), .in_full(in_full), .req(req), .idx(idx),
        .data_count(data_count), .valid_count(valid_count), .state(state), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference: queues per FIFO, one optional in-flight word, plain ints.
    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;
    logic [DATA_W-1:0] m_in  [NUM_CH][$];
    logic [DATA_W-1:0] m_out [NUM_CH][$];
    logic [DATA_W-1:0] m_dout[NUM_CH];
    int                m_cnt [NUM_CH];
    logic [DATA_W-1:0] m_pipe;
    bit                m_pipe_v, m_vcount;
    int                m_state, m_rr, m_L, m_H, m_dcount;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_in[i].delete();
            m_out[i].delete();
            m_dout[i] = '0;
            m_cnt[i]  = 0;
        end
        m_pipe_v = 0; m_pipe = '0; m_vcount = 0; m_dcount = 0;
        m_state = S_RESET; m_rr = 0; m_L = 1; m_H = DEPTH - 1;
    endtask

    task automatic model_step();
        bit afull, any_in, all_empty, err;
        bit full[NUM_CH];
        logic [DATA_W-1:0] w;
        int c, d;
        if (reset) begin
            model_reset();
            return;
        end
        afull = 0; any_in = 0; all_empty = !m_pipe_v;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_out[i].size() >= m_H) afull = 1;
            if (m_in[i].size() > 0) any_in = 1;
            if (m_out[i].size() > 0) all_empty = 0;
            full[i] = (m_in[i].size() == DEPTH);
        end
        if (any_in) all_empty = 0;

        if (req) m_dcount = m_cnt[idx];
        m_vcount = req;

        for (int i = 0; i < NUM_CH; i++) begin
            if (pop[i] && m_out[i].size() > 0) begin
                m_dout[i] = m_out[i].pop_front();
                m_cnt[i]  = (m_cnt[i] + 1) % (1 << CNT_W);
            end
        end
        if (m_pipe_v) begin
            w = m_pipe;
            d = int'(w[DATA_W-CH_W-1 -: CH_W]);
            m_out[d].push_back(m_pipe);
        end

        m_pipe_v = 0;
        if (m_state == S_ACTIVE && !afull) begin
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef ARB_STRICT_PRIO_EN
                c = k;
`else
                c = (m_rr + k) % NUM_CH;
`endif
                if (!m_pipe_v && m_in[c].size() > 0) begin
                    m_pipe   = m_in[c].pop_front();
                    m_pipe_v = 1;
                    m_rr     = (c + 1) % NUM_CH;
                end
            end
        end

        err = 0;
        if (push && m_state != S_RESET && m_state != S_INIT) begin
            w = data_in;
            c = int'(w[DATA_W-1 -: CH_W]);
            if (full[c]) err = 1;
            else m_in[c].push_back(data_in);
        end

        case (m_state)
            S_RESET: m_state = S_INIT;
            S_INIT: begin
                m_L = int'(umbral_L);
                m_H = (int'(umbral_H) > DEPTH - 1) ? DEPTH - 1 : int'(umbral_H);
                if (!init) m_state = S_IDLE;
            end
            default: begin
                if (init) begin
                    if (m_state == S_ERROR) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            m_in[i].delete();
                            m_out[i].delete();
                        end
                        m_pipe_v = 0;
                    end
                    m_state = S_INIT;
                end else if (err) m_state = S_ERROR;
                else if (m_state == S_IDLE && any_in) m_state = S_ACTIVE;
                else if (m_state == S_ACTIVE && all_empty) m_state = S_IDLE;
            end
        endcase
    endtask

    task automatic compare_all();
        logic [NUM_CH*DATA_W-1:0] e_dout;
        logic [NUM_CH-1:0] e_emp, e_af, e_ae, e_full;
        for (int i = 0; i < NUM_CH; i++) begin
            e_dout[i*DATA_W +: DATA_W] = m_dout[i];
            e_emp[i]  = (m_out[i].size() == 0);
            e_af[i]   = (m_out[i].size() >= m_H);
            e_ae[i]   = (m_out[i].size() <= m_L);
            e_full[i] = (m_in[i].size() == DEPTH);
        end
        expect_eq("state", 64'(state), 64'(m_state));
        expect_eq("idle", 64'(idle), 64'(m_state == S_IDLE));
        expect_eq("data_out", 64'(data_out), 64'(e_dout));
        expect_eq("out_empty", 64'(out_empty), 64'(e_emp));
        expect_eq("out_almost_full", 64'(out_almost_full), 64'(e_af));
        expect_eq("out_almost_empty", 64'(out_almost_empty), 64'(e_ae));
        expect_eq("in_full", 64'(in_full), 64'(e_full));
        expect_eq("valid_count", 64'(valid_count), 64'(m_vcount));
        expect_eq("data_count", 64'(data_count), 64'(m_dcount % (1 << CNT_W)));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic push_word(input int cls, input int dst, output logic [DATA_W-1:0] w);
        logic [CH_W-1:0] c2, d2;
        logic [7:0] pay;
        c2 = CH_W'(cls); d2 = CH_W'(dst); pay = 8'($urandom);
        w = {c2, d2, pay};
        data_in = w; push = 1'b1;
        cycle();
        push = 1'b0;
    endtask

    task automatic do_init(input int l, input int h);
        umbral_L = OCC_W'(l); umbral_H = OCC_W'(h); init = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
    endtask

    logic [DATA_W-1:0] w, w3[4];

    initial begin
        reset = 1'b1; init = 1'b0; push = 1'b0; req = 1'b0; pop = '0; idx = '0;
        data_in = '0; umbral_L = '0; umbral_H = '0;
        model_reset();

        // T1: reset, INIT with L=2 H=6, then IDLE
        cycle();
        expect_eq("t1_reset_state", 64'(state), 64'(S_RESET));
        reset = 1'b0; init = 1'b1; umbral_L = 4'd2; umbral_H = 4'd6;
        cycle();
        expect_eq("t1_init_state", 64'(state), 64'(S_INIT));
        cycle();
        init = 1'b0;
        cycle();
        expect_eq("t1_idle_state", 64'(state), 64'(S_IDLE));

        // T2: four words per class, dest = class
        for (int k = 0; k < 16; k++) push_word(k % NUM_CH, k % NUM_CH, w);
        idle_cycles(8);
        expect_eq("t2_active", 64'(state), 64'(S_ACTIVE));
        expect_eq("t2_out_empty", 64'(out_empty), 64'(0));

        // T3: H=5, a fifth word per output -> stall, pop resumes
        do_init(1, 5);
        for (int k = 0; k < NUM_CH; k++) push_word(k, k, w);
        idle_cycles(6);
        expect_eq("t3_any_afull", 64'(|out_almost_full), 64'(1));
        expect_eq("t3_stalled_active", 64'(state), 64'(S_ACTIVE));
        pop = 4'b0011;
        cycle();
        pop = '0;
        idle_cycles(6);

        // T4: overfill input FIFO 0 while stalled
        for (int k = 0; k < DEPTH; k++) push_word(0, 1, w);
        expect_eq("t4_in_full0", 64'(in_full[0]), 64'(1));
        push_word(0, 1, w);
        expect_eq("t4_error", 64'(state), 64'(S_ERROR));
        idle_cycles(2);
        expect_eq("t4_error_sticky", 64'(state), 64'(S_ERROR));

        // Leave ERROR through INIT (flush), then T5
        do_init(1, 7);
        expect_eq("flush_idle", 64'(state), 64'(S_IDLE));
        expect_eq("flush_empty", 64'(out_empty), 64'(4'hF));
        for (int k = 0; k < 4; k++) push_word(3, 3, w3[k]);
        idle_cycles(8);
        pop = 4'b1000;
        idle_cycles(17);
        pop = '0;
        expect_eq("t5_last_word", 64'(data_out[3*DATA_W +: DATA_W]), 64'(w3[3]));
        req = 1'b1; idx = 2'd3;
        cycle();
        req = 1'b0;
        expect_eq("t5_count", 64'(data_count), 64'(4));
        expect_eq("t5_valid", 64'(valid_count), 64'(1));
        cycle();
        expect_eq("t5_valid_drop", 64'(valid_count), 64'(0));
        expect_eq("t5_idle", 64'(state), 64'(S_IDLE));

        // Random traffic with periodic re-INIT (also recovers from ERROR)
        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 39) begin
                push = 1'b0; pop = '0; req = 1'b0;
                do_init($urandom_range(0, 7), $urandom_range(3, 15));
            end
            push = ($urandom_range(0, 1) == 1);
            data_in = DATA_W'($urandom);
            pop = NUM_CH'($urandom);
            req = ($urandom_range(0, 3) == 0);
            idx = CH_W'($urandom);
            cycle();
        end

        // T6: reset mid-traffic
        reset = 1'b1;
        cycle();
        reset = 1'b0; push = 1'b0; pop = '0; req = 1'b0;
        expect_eq("t6_state", 64'(state), 64'(S_RESET));
        expect_eq("t6_data_out", 64'(data_out), 64'(0));
        expect_eq("t6_out_empty", 64'(out_empty), 64'(4'hF));
        expect_eq("t6_count", 64'(data_count), 64'(0));
        idle_cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
